// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundles the functional-unit result handshake, the squash
// input and the common-data-bus broadcast outputs for cdb_arbiter.
// The slave modport is the arbiter side; the master modport is the side
// that drives FU results and observes the CDB (FUs, ROB/RS, testbench).
// XLEN and ROB_TAG_LEN default here when the surrounding build leaves them
// undefined.

`ifndef XLEN
`define XLEN 32
`endif

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

interface cdb_arbiter_if #(
  parameter int FU_NUM = 4
);

  localparam int SEL_W = $clog2(FU_NUM);

  logic                                squash;
  logic [FU_NUM-1:0]                   fu_valid;
  logic [FU_NUM-1:0][`XLEN-1:0]        fu_value;
  logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0] fu_rob_tag;
  logic                                btu_mispredict;
  logic [`XLEN-1:0]                    btu_pc;

  logic [FU_NUM-1:0]                   fu_ready;
  logic                                cdb_valid;
  logic [SEL_W-1:0]                    cdb_select;
  logic [`ROB_TAG_LEN-1:0]             cdb_rob_tag;
  logic [`XLEN-1:0]                    cdb_value;
  logic                                cdb_mispredict;
  logic [`XLEN-1:0]                    cdb_pc;

  modport slave (
    input  squash,
    input  fu_valid,
    input  fu_value,
    input  fu_rob_tag,
    input  btu_mispredict,
    input  btu_pc,
    output fu_ready,
    output cdb_valid,
    output cdb_select,
    output cdb_rob_tag,
    output cdb_value,
    output cdb_mispredict,
    output cdb_pc
  );

  modport master (
    output squash,
    output fu_valid,
    output fu_value,
    output fu_rob_tag,
    output btu_mispredict,
    output btu_pc,
    input  fu_ready,
    input  cdb_valid,
    input  cdb_select,
    input  cdb_rob_tag,
    input  cdb_value,
    input  cdb_mispredict,
    input  cdb_pc
  );

endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: arbitrates the single common data bus between FU_NUM
// functional units. Each FU deposits its finished result into a one-entry
// holding slot; every cycle one occupied slot is granted and registered onto
// the CDB outputs feeding the ROB and the reservation stations. Only the
// branch unit slot (BTU_IDX) carries the mispredict flag and target PC.
//
// Configuration macro CDB_ARB_ROUND_ROBIN_EN:
//   defined   -> round-robin arbitration starting at a rotating pointer
//   undefined -> fixed priority: BTU slot first, then lowest index
//                (no pointer register exists in this build)

`ifndef XLEN
`define XLEN 32
`endif

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module cdb_arbiter #(
  parameter int FU_NUM  = 4,
  parameter int BTU_IDX = 3
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
);

  localparam int              SEL_W   = $clog2(FU_NUM);
  localparam logic [SEL_W-1:0] BTU_SEL = SEL_W'(BTU_IDX);

  // Holding slots, one per functional unit
  logic [FU_NUM-1:0]                   slotValid_q, slotValid_d;
  logic [FU_NUM-1:0][`XLEN-1:0]        slotValue_q, slotValue_d;
  logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0] slotTag_q,   slotTag_d;

  // Extra branch-unit payload, only meaningful while the BTU slot is valid
  logic                                btuMispredict_q, btuMispredict_d;
  logic [`XLEN-1:0]                    btuPc_q,         btuPc_d;

  // Registered CDB broadcast
  logic                                cdbValid_q,     cdbValid_d;
  logic [SEL_W-1:0]                    cdbSelect_q,    cdbSelect_d;
  logic [`ROB_TAG_LEN-1:0]             cdbTag_q,       cdbTag_d;
  logic [`XLEN-1:0]                    cdbValue_q,     cdbValue_d;
  logic                                cdbMispredict_q, cdbMispredict_d;
  logic [`XLEN-1:0]                    cdbPc_q,        cdbPc_d;

  // Arbitration result and handshake
  logic [FU_NUM-1:0]                   grant;
  logic                                anyGrant;
  logic [SEL_W-1:0]                    winIdx;
  logic [FU_NUM-1:0]                   fuReady;
  logic [FU_NUM-1:0]                   accept;

`ifdef CDB_ARB_ROUND_ROBIN_EN

  logic [SEL_W-1:0]                    rrPtr_q, rrPtr_d;
  logic [SEL_W:0]                      rrSum;
  logic [SEL_W-1:0]                    rrIdx;

  // Round-robin pick: scan from the pointer upward, wrapping at FU_NUM
  always_comb begin
    grant    = '0;
    anyGrant = 1'b0;
    winIdx   = '0;
    rrSum    = '0;
    rrIdx    = '0;
    for (int k = 0; k < FU_NUM; k++) begin
      rrSum = {1'b0, rrPtr_q} + (SEL_W+1)'(k);
      if (rrSum >= (SEL_W+1)'(FU_NUM)) begin
        rrSum = rrSum - (SEL_W+1)'(FU_NUM);
      end
      rrIdx = rrSum[SEL_W-1:0];
      if (!anyGrant && slotValid_q[rrIdx]) begin
        anyGrant = 1'b1;
        winIdx   = rrIdx;
      end
    end
    if (anyGrant) begin
      grant[winIdx] = 1'b1;
    end
  end

  // Pointer moves past the winner; a squash cycle broadcasts nothing, so it holds
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (anyGrant && !bus.squash) begin
      if (winIdx == SEL_W'(FU_NUM - 1)) begin
        rrPtr_d = '0;
      end else begin
        rrPtr_d = winIdx + SEL_W'(1);
      end
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rrPtr_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

`else

  // Fixed priority: the branch unit wins outright, otherwise lowest index wins
  always_comb begin
    grant    = '0;
    anyGrant = 1'b0;
    winIdx   = '0;
    if (slotValid_q[BTU_SEL]) begin
      anyGrant = 1'b1;
      winIdx   = BTU_SEL;
    end else begin
      for (int k = FU_NUM - 1; k >= 0; k--) begin
        if (slotValid_q[k]) begin
          anyGrant = 1'b1;
          winIdx   = SEL_W'(k);
        end
      end
    end
    if (anyGrant) begin
      grant[winIdx] = 1'b1;
    end
  end

`endif

  // A slot is ready when empty or draining this cycle; squash and reset block all intake
  always_comb begin
    if (reset || bus.squash) begin
      fuReady = '0;
    end else begin
      fuReady = ~slotValid_q | grant;
    end
    accept = bus.fu_valid & fuReady;
  end

  // Next-state for slots and for the CDB output registers
  always_comb begin
    slotValid_d     = slotValid_q;
    slotValue_d     = slotValue_q;
    slotTag_d       = slotTag_q;
    btuMispredict_d = btuMispredict_q;
    btuPc_d         = btuPc_q;

    cdbValid_d      = 1'b0;
    cdbSelect_d     = '0;
    cdbTag_d        = '0;
    cdbValue_d      = '0;
    cdbMispredict_d = 1'b0;
    cdbPc_d         = '0;

    if (bus.squash) begin
      slotValid_d = '0;
    end else begin
      for (int i = 0; i < FU_NUM; i++) begin
        if (accept[i]) begin
          slotValid_d[i] = 1'b1;
          slotValue_d[i] = bus.fu_value[i];
          slotTag_d[i]   = bus.fu_rob_tag[i];
        end else if (grant[i]) begin
          slotValid_d[i] = 1'b0;
        end
      end

      if (accept[BTU_IDX]) begin
        btuMispredict_d = bus.btu_mispredict;
        btuPc_d         = bus.btu_pc;
      end

      if (anyGrant) begin
        cdbValid_d  = 1'b1;
        cdbSelect_d = winIdx;
        cdbTag_d    = slotTag_q[winIdx];
        cdbValue_d  = slotValue_q[winIdx];
        if (winIdx == BTU_SEL) begin
          cdbMispredict_d = btuMispredict_q;
          cdbPc_d         = btuPc_q;
        end
      end
    end
  end

  // Slot and CDB registers; reset discards every in-flight result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slotValid_q     <= '0;
      slotValue_q     <= '0;
      slotTag_q       <= '0;
      btuMispredict_q <= 1'b0;
      btuPc_q         <= '0;
      cdbValid_q      <= 1'b0;
      cdbSelect_q     <= '0;
      cdbTag_q        <= '0;
      cdbValue_q      <= '0;
      cdbMispredict_q <= 1'b0;
      cdbPc_q         <= '0;
    end else begin
      slotValid_q     <= slotValid_d;
      slotValue_q     <= slotValue_d;
      slotTag_q       <= slotTag_d;
      btuMispredict_q <= btuMispredict_d;
      btuPc_q         <= btuPc_d;
      cdbValid_q      <= cdbValid_d;
      cdbSelect_q     <= cdbSelect_d;
      cdbTag_q        <= cdbTag_d;
      cdbValue_q      <= cdbValue_d;
      cdbMispredict_q <= cdbMispredict_d;
      cdbPc_q         <= cdbPc_d;
    end
  end

  assign bus.fu_ready       = fuReady;
  assign bus.cdb_valid      = cdbValid_q;
  assign bus.cdb_select     = cdbSelect_q;
  assign bus.cdb_rob_tag    = cdbTag_q;
  assign bus.cdb_value      = cdbValue_q;
  assign bus.cdb_mispredict = cdbMispredict_q;
  assign bus.cdb_pc         = cdbPc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter. Expected broadcasts are
// queued when results are presented and popped by a monitor whenever the
// CDB shows a valid broadcast; idle cycles must show all-zero CDB fields.

`ifndef XLEN
`define XLEN 32
`endif

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_cdb_arbiter;

  localparam int FU_NUM  = 4;
  localparam int BTU_IDX = 3;

  typedef struct {
    logic [1:0]              sel;
    logic [`ROB_TAG_LEN-1:0] tag;
    logic [`XLEN-1:0]        value;
    logic                    misp;
    logic [`XLEN-1:0]        pc;
  } bcast_t;

  logic clock = 1'b0;
  logic reset;

  int     checkCount = 0;
  int     passCount  = 0;
  bcast_t expQ[$];
  bit     monEnable  = 1'b0;

  cdb_arbiter_if #(.FU_NUM(FU_NUM)) bus ();

  cdb_arbiter #(
    .FU_NUM (FU_NUM),
    .BTU_IDX(BTU_IDX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, 10 time-unit period
  always #5 clock = ~clock;

  // Monitor: pop one expected entry per broadcast, require zeros when idle
  always @(negedge clock) begin
    bcast_t e;
    if (monEnable && !reset) begin
      checkCount++;
      if (bus.cdb_valid) begin
        if (expQ.size() == 0) begin
          $display("[TB] FAIL unexpected_bcast: got sel %0d tag %0d value %h, required no broadcast",
                   bus.cdb_select, bus.cdb_rob_tag, bus.cdb_value);
        end else begin
          e = expQ.pop_front();
          if ({bus.cdb_select, bus.cdb_rob_tag, bus.cdb_value, bus.cdb_mispredict, bus.cdb_pc}
              !== {e.sel, e.tag, e.value, e.misp, e.pc}) begin
            $display("[TB] FAIL bcast: got sel %0d tag %0d value %h misp %b pc %h, required sel %0d tag %0d value %h misp %b pc %h",
                     bus.cdb_select, bus.cdb_rob_tag, bus.cdb_value, bus.cdb_mispredict, bus.cdb_pc,
                     e.sel, e.tag, e.value, e.misp, e.pc);
          end else begin
            passCount++;
          end
        end
      end else begin
        if ({bus.cdb_select, bus.cdb_rob_tag, bus.cdb_value, bus.cdb_mispredict, bus.cdb_pc} !== '0) begin
          $display("[TB] FAIL idle_zero: got sel %0d tag %0d value %h misp %b pc %h, required all 0",
                   bus.cdb_select, bus.cdb_rob_tag, bus.cdb_value, bus.cdb_mispredict, bus.cdb_pc);
        end else begin
          passCount++;
        end
      end
    end
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] time limit reached");
  end

  function automatic void pushExp(input int sel, input int tag, input logic [`XLEN-1:0] value,
                                  input logic misp, input logic [`XLEN-1:0] pc);
    bcast_t e;
    e.sel   = 2'(sel);
    e.tag   = `ROB_TAG_LEN'(tag);
    e.value = value;
    e.misp  = misp;
    e.pc    = pc;
    expQ.push_back(e);
  endfunction

  task automatic clearInputs();
    bus.squash         = 1'b0;
    bus.fu_valid       = '0;
    bus.fu_value       = '0;
    bus.fu_rob_tag     = '0;
    bus.btu_mispredict = 1'b0;
    bus.btu_pc         = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic waitDrain(input string name);
    for (int c = 0; c < 20; c++) begin
      if (expQ.size() == 0) break;
      tick();
    end
    tick();
    checkCount++;
    if (expQ.size() != 0) begin
      $display("[TB] FAIL %s_drain: %0d broadcasts still outstanding, required 0", name, expQ.size());
      expQ.delete();
    end else begin
      passCount++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clearInputs();
    #12;
    checkCount++;
    if (bus.fu_ready !== 4'b0000) begin
      $display("[TB] FAIL reset_ready: got %b, required 0000", bus.fu_ready);
    end else passCount++;
    checkCount++;
    if ({bus.cdb_valid, bus.cdb_select, bus.cdb_rob_tag, bus.cdb_value, bus.cdb_mispredict, bus.cdb_pc} !== '0) begin
      $display("[TB] FAIL reset_cdb: got valid %b sel %0d value %h, required all 0",
               bus.cdb_valid, bus.cdb_select, bus.cdb_value);
    end else passCount++;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkCount++;
    if (bus.fu_ready !== 4'b1111) begin
      $display("[TB] FAIL post_reset_ready: got %b, required 1111", bus.fu_ready);
    end else passCount++;
    monEnable = 1'b1;
  endtask

  task automatic test_simultaneous();
    int         ord[4];
    logic [3:0] emptied;
    logic [3:0] readyExp;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    ord = '{0, 1, 2, 3};
`else
    ord = '{3, 0, 1, 2};
`endif
    tick();
    bus.fu_valid = 4'b1111;
    for (int i = 0; i < FU_NUM; i++) begin
      bus.fu_rob_tag[i] = `ROB_TAG_LEN'(i);
      bus.fu_value[i]   = `XLEN'(32'h100 + i);
    end
    for (int k = 0; k < 4; k++) begin
      pushExp(ord[k], ord[k], `XLEN'(32'h100 + ord[k]), 1'b0, '0);
    end
    tick();
    clearInputs();
    emptied = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      readyExp = emptied | (4'b0001 << ord[k]);
      checkCount++;
      if (bus.fu_ready !== readyExp) begin
        $display("[TB] FAIL simul_ready_%0d: got %b, required %b", k, bus.fu_ready, readyExp);
      end else passCount++;
      emptied = readyExp;
      tick();
    end
    checkCount++;
    if (bus.fu_ready !== 4'b1111) begin
      $display("[TB] FAIL simul_ready_end: got %b, required 1111", bus.fu_ready);
    end else passCount++;
    waitDrain("simul");
  endtask

  task automatic test_single();
    tick();
    bus.fu_valid      = 4'b0010;
    bus.fu_value[1]   = `XLEN'(32'hDEAD);
    bus.fu_rob_tag[1] = `ROB_TAG_LEN'(5);
    pushExp(1, 5, `XLEN'(32'hDEAD), 1'b0, '0);
    #1;
    checkCount++;
    if (bus.fu_ready[1] !== 1'b1) begin
      $display("[TB] FAIL single_ready: got %b, required 1", bus.fu_ready[1]);
    end else passCount++;
    tick();
    clearInputs();
    checkCount++;
    if (bus.cdb_valid !== 1'b0) begin
      $display("[TB] FAIL single_early: got valid %b one edge after accept, required 0", bus.cdb_valid);
    end else passCount++;
    tick();
    checkCount++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_select !== 2'd1) begin
      $display("[TB] FAIL single_latency: got valid %b sel %0d, required valid 1 sel 1", bus.cdb_valid, bus.cdb_select);
    end else passCount++;
    tick();
    checkCount++;
    if (bus.cdb_valid !== 1'b0) begin
      $display("[TB] FAIL single_width: got valid %b on second cycle, required 0", bus.cdb_valid);
    end else passCount++;
    waitDrain("single");
  endtask

  task automatic test_mispredict();
    tick();
    bus.fu_valid       = 4'b1000;
    bus.fu_rob_tag[3]  = `ROB_TAG_LEN'(9);
    bus.fu_value[3]    = `XLEN'(32'h55);
    bus.btu_mispredict = 1'b1;
    bus.btu_pc         = `XLEN'(32'h1000);
    pushExp(3, 9, `XLEN'(32'h55), 1'b1, `XLEN'(32'h1000));
    tick();
    bus.fu_valid      = 4'b0001;
    bus.fu_rob_tag[0] = `ROB_TAG_LEN'(10);
    bus.fu_value[0]   = `XLEN'(32'h66);
    pushExp(0, 10, `XLEN'(32'h66), 1'b0, '0);
    tick();
    clearInputs();
    checkCount++;
    if (bus.cdb_mispredict !== 1'b1 || bus.cdb_pc !== `XLEN'(32'h1000)) begin
      $display("[TB] FAIL btu_bcast: got misp %b pc %h, required misp 1 pc 00001000", bus.cdb_mispredict, bus.cdb_pc);
    end else passCount++;
    tick();
    checkCount++;
    if (bus.cdb_select !== 2'd0 || bus.cdb_mispredict !== 1'b0 || bus.cdb_pc !== '0) begin
      $display("[TB] FAIL non_btu_bcast: got sel %0d misp %b pc %h, required sel 0 misp 0 pc 0",
               bus.cdb_select, bus.cdb_mispredict, bus.cdb_pc);
    end else passCount++;
    waitDrain("mispredict");
  endtask

  task automatic test_squash();
    tick();
    bus.fu_valid      = 4'b0101;
    bus.fu_rob_tag[0] = `ROB_TAG_LEN'(1);
    bus.fu_rob_tag[2] = `ROB_TAG_LEN'(2);
    bus.fu_value[0]   = `XLEN'(32'hA0);
    bus.fu_value[2]   = `XLEN'(32'hA2);
    tick();
    clearInputs();
    bus.squash        = 1'b1;
    bus.fu_valid      = 4'b0010;
    bus.fu_rob_tag[1] = `ROB_TAG_LEN'(3);
    bus.fu_value[1]   = `XLEN'(32'hA1);
    #1;
    checkCount++;
    if (bus.fu_ready !== 4'b0000) begin
      $display("[TB] FAIL squash_ready: got %b, required 0000", bus.fu_ready);
    end else passCount++;
    tick();
    checkCount++;
    if (bus.cdb_valid !== 1'b0) begin
      $display("[TB] FAIL squash_cdb: got valid %b, required 0", bus.cdb_valid);
    end else passCount++;
    clearInputs();
    #1;
    checkCount++;
    if (bus.fu_ready !== 4'b1111) begin
      $display("[TB] FAIL post_squash_ready: got %b, required 1111", bus.fu_ready);
    end else passCount++;
    for (int c = 0; c < 4; c++) tick();
    waitDrain("squash");
  endtask

  task automatic test_back_to_back();
    tick();
    for (int k = 0; k < 10; k++) begin
      bus.fu_valid      = 4'b0001;
      bus.fu_rob_tag[0] = `ROB_TAG_LEN'(k);
      bus.fu_value[0]   = `XLEN'(32'hA000 + k);
      pushExp(0, k, `XLEN'(32'hA000 + k), 1'b0, '0);
      #1;
      checkCount++;
      if (bus.fu_ready[0] !== 1'b1) begin
        $display("[TB] FAIL b2b_ready_%0d: got %b, required 1", k, bus.fu_ready[0]);
      end else passCount++;
      tick();
      if (k >= 1) begin
        checkCount++;
        if (bus.cdb_valid !== 1'b1) begin
          $display("[TB] FAIL b2b_valid_%0d: got %b, required 1", k, bus.cdb_valid);
        end else passCount++;
      end
    end
    clearInputs();
    tick();
    checkCount++;
    if (bus.cdb_valid !== 1'b1) begin
      $display("[TB] FAIL b2b_last: got %b, required 1", bus.cdb_valid);
    end else passCount++;
    tick();
    checkCount++;
    if (bus.cdb_valid !== 1'b0) begin
      $display("[TB] FAIL b2b_after: got %b, required 0", bus.cdb_valid);
    end else passCount++;
    waitDrain("b2b");
  endtask

  task automatic test_reset_mid();
    monEnable = 1'b0;
    tick();
    bus.fu_valid = 4'b1111;
    for (int i = 0; i < FU_NUM; i++) begin
      bus.fu_rob_tag[i] = `ROB_TAG_LEN'(20 + i);
      bus.fu_value[i]   = `XLEN'(32'hC00 + i);
    end
    tick();
    clearInputs();
    tick();
    checkCount++;
    if (bus.cdb_valid !== 1'b1) begin
      $display("[TB] FAIL midreset_pre: got valid %b, required 1", bus.cdb_valid);
    end else passCount++;
    #2;
    reset = 1'b1;
    #1;
    checkCount++;
    if ({bus.cdb_valid, bus.cdb_select, bus.cdb_rob_tag, bus.cdb_value, bus.cdb_mispredict, bus.cdb_pc} !== '0
        || bus.fu_ready !== 4'b0000) begin
      $display("[TB] FAIL midreset_clear: got valid %b sel %0d value %h ready %b, required all 0",
               bus.cdb_valid, bus.cdb_select, bus.cdb_value, bus.fu_ready);
    end else passCount++;
    expQ.delete();
    @(negedge clock);
    reset = 1'b0;
    monEnable = 1'b1;
    tick();
    bus.fu_valid      = 4'b0100;
    bus.fu_rob_tag[2] = `ROB_TAG_LEN'(30);
    bus.fu_value[2]   = `XLEN'(32'hBEEF);
    pushExp(2, 30, `XLEN'(32'hBEEF), 1'b0, '0);
    tick();
    clearInputs();
    for (int c = 0; c < 3; c++) tick();
    waitDrain("midreset");
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single();
    test_mispredict();
    test_squash();
    test_back_to_back();
    test_reset_mid();
    monEnable = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
